// File: rtl/tft_window_reader_if.sv
// Bundle of signals between the TFT window reader, the timing generator and
// the read port of the dual-port frame RAM.
//   slave  : the window reader itself
//   master : the timing generator / RAM side that drives requests and data
interface tft_window_reader_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 11,
    parameter int unsigned PIX_AW = 16
);
    logic              data_req;
    logic [CNT_W-1:0]  h_cnt;
    logic [CNT_W-1:0]  v_cnt;
    logic              scale_2x;
    logic              bank_sel;
    logic [PIX_AW:0]   ram_rdaddr;
    logic [DATA_W-1:0] ram_rddata;
    logic [DATA_W-1:0] disp_data;
    logic              frame_done;
    logic              cur_bank;

    modport slave (
        input  data_req, h_cnt, v_cnt, scale_2x, bank_sel, ram_rddata,
        output ram_rdaddr, disp_data, frame_done, cur_bank
    );

    modport master (
        output data_req, h_cnt, v_cnt, scale_2x, bank_sel, ram_rddata,
        input  ram_rdaddr, disp_data, frame_done, cur_bank
    );
endinterface

// File: rtl/tft_window_reader.sv
// Read-side controller between the dual-port frame RAM and the TFT timing
// generator. Places an IMG_W x IMG_H image at (WIN_X, WIN_Y), optionally
// replicating every pixel 2x in both directions, and reads from the bank
// latched at frame start. Addresses come from counters (no multiplier).
// RAM read data is realigned with the window flag so that disp_data for a
// (data_req, h_cnt, v_cnt) sample appears RAM_LAT+1 cycles later; pixels
// outside the window show BG_COLOR.
module tft_window_reader #(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       CNT_W    = 11,
    parameter int unsigned       PIX_AW   = 16,
    parameter int unsigned       IMG_W    = 256,
    parameter int unsigned       IMG_H    = 256,
    parameter int unsigned       WIN_X    = 272,
    parameter int unsigned       WIN_Y    = 112,
    parameter int unsigned       RAM_LAT  = 1,
    parameter logic [DATA_W-1:0] BG_COLOR = 16'h0000
) (
    input  logic                TFT_CLK,
    input  logic                rst_n,
    tft_window_reader_if.slave  tft
);

    // Window geometry in CNT_W+1 bits so the window end never overflows.
    localparam logic [CNT_W:0]  C_WIN_X  = (CNT_W+1)'(WIN_X);
    localparam logic [CNT_W:0]  C_WIN_Y  = (CNT_W+1)'(WIN_Y);
    localparam logic [CNT_W:0]  C_W_1X   = (CNT_W+1)'(IMG_W);
    localparam logic [CNT_W:0]  C_W_2X   = (CNT_W+1)'(2 * IMG_W);
    localparam logic [CNT_W:0]  C_H_1X   = (CNT_W+1)'(IMG_H);
    localparam logic [CNT_W:0]  C_H_2X   = (CNT_W+1)'(2 * IMG_H);
    localparam logic [PIX_AW-1:0] C_ROW_STEP = PIX_AW'(IMG_W);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic               r_active;      // a frame start has been seen since reset
    logic               r_scale;       // replication factor latched at frame start
    logic               r_cur_bank;    // bank latched at frame start
    logic [PIX_AW-1:0]  r_row_base;    // first pixel of the image row being read
    logic [PIX_AW-1:0]  r_col;         // image column within the row
    logic               r_col_sub;     // 2x: second sample of the same column
    logic               r_line_sub;    // 2x: second line of the same image row
    logic               r_fired;       // last window address already issued
    logic               r_at_end_q;    // h_cnt sat on the line end last cycle
    logic [PIX_AW:0]    r_ram_rdaddr;
    logic [RAM_LAT-1:0] r_win_pipe;    // in_win delayed to meet RAM data
    logic [RAM_LAT-1:0] r_done_pipe;   // last-address strobe delayed likewise
    logic [DATA_W-1:0]  r_disp_data;
    logic               r_frame_done;

    // ------------------------------------------------------------------
    // Frame-start view: on the (0,0) cycle the clears and the freshly
    // sampled scale/bank apply to this same cycle, so a window placed at
    // the origin issues {bank_sel, 0} first.
    // ------------------------------------------------------------------
    logic               w_frame_start;
    logic               w_scale;
    logic               w_bank;
    logic [PIX_AW-1:0]  w_row_base;
    logic [PIX_AW-1:0]  w_col;
    logic               w_col_sub;
    logic               w_line_sub;
    logic               w_fired;

    assign w_frame_start = (tft.h_cnt == '0) && (tft.v_cnt == '0);
    assign w_scale       = w_frame_start ? tft.scale_2x : r_scale;
    assign w_bank        = w_frame_start ? tft.bank_sel : r_cur_bank;
    assign w_row_base    = w_frame_start ? '0   : r_row_base;
    assign w_col         = w_frame_start ? '0   : r_col;
    assign w_col_sub     = w_frame_start ? 1'b0 : r_col_sub;
    assign w_line_sub    = w_frame_start ? 1'b0 : r_line_sub;
    assign w_fired       = w_frame_start ? 1'b0 : r_fired;

    // ------------------------------------------------------------------
    // Window decode. The offset from the window origin is taken modulo
    // 2^(CNT_W+1): a counter left of / above the origin wraps to a value
    // larger than any window size, so one compare covers both bounds.
    // ------------------------------------------------------------------
    logic [CNT_W:0] w_h;
    logic [CNT_W:0] w_v;
    logic [CNT_W:0] w_h_off;
    logic [CNT_W:0] w_v_off;
    logic [CNT_W:0] w_w_eff;
    logic [CNT_W:0] w_h_eff;
    logic           w_in_h;
    logic           w_in_v;
    logic           w_in_win;
    logic           w_at_end;
    logic           w_line_end;
    logic           w_last_pix;

    assign w_h        = {1'b0, tft.h_cnt};
    assign w_v        = {1'b0, tft.v_cnt};
    assign w_h_off    = w_h - C_WIN_X;
    assign w_v_off    = w_v - C_WIN_Y;
    assign w_w_eff    = w_scale ? C_W_2X : C_W_1X;
    assign w_h_eff    = w_scale ? C_H_2X : C_H_1X;
    assign w_in_h     = (w_h_off < w_w_eff);
    assign w_in_v     = (w_v_off < w_h_eff);
    // After reset the frame is aborted until the next frame start.
    assign w_in_win   = tft.data_req && (r_active || w_frame_start) && w_in_h && w_in_v;
    assign w_at_end   = (w_h_off == w_w_eff);
    assign w_line_end = w_at_end && !r_at_end_q;
    assign w_last_pix = w_in_win && !w_fired &&
                        (w_h_off == w_w_eff - 1'b1) && (w_v_off == w_h_eff - 1'b1);

    // ------------------------------------------------------------------
    // Next values of the address counters
    // ------------------------------------------------------------------
    logic [PIX_AW-1:0] w_row_base_nxt;
    logic [PIX_AW-1:0] w_col_nxt;
    logic              w_col_sub_nxt;
    logic              w_line_sub_nxt;

    // Column advances every (1 << scale) window samples; row base advances
    // at each window line end, only every second line in 2x mode.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_row_base_nxt = w_row_base;
        w_col_nxt      = w_col;
        w_col_sub_nxt  = w_col_sub;
        w_line_sub_nxt = w_line_sub;
        if (w_in_win) begin
            if (!w_scale || w_col_sub) begin
                w_col_nxt = w_col + 1'b1;
            end
            w_col_sub_nxt = w_scale && !w_col_sub;
        end
        if (w_line_end) begin
            w_col_nxt     = '0;
            w_col_sub_nxt = 1'b0;
            if (w_in_v) begin
                if (!w_scale || w_line_sub) begin
                    w_row_base_nxt = w_row_base + C_ROW_STEP;
                end
                w_line_sub_nxt = w_scale && !w_line_sub;
            end
        end
    end

    // Frame-level control and address counters.
    always_ff @(posedge TFT_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_active   <= 1'b0;
            r_scale    <= 1'b0;
            r_cur_bank <= 1'b0;
            r_row_base <= '0;
            r_col      <= '0;
            r_col_sub  <= 1'b0;
            r_line_sub <= 1'b0;
            r_fired    <= 1'b0;
            r_at_end_q <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
            if (w_frame_start) begin
                r_active <= 1'b1;
            end
            r_scale    <= w_scale;
            r_cur_bank <= w_bank;
            r_row_base <= w_row_base_nxt;
            r_col      <= w_col_nxt;
            r_col_sub  <= w_col_sub_nxt;
            r_line_sub <= w_line_sub_nxt;
            r_fired    <= w_fired || w_last_pix;
            r_at_end_q <= w_at_end;
        end
    end

    // Issue {bank, row_base + col} on window samples; hold otherwise.
    always_ff @(posedge TFT_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_rdaddr <= '0;
        end else if (w_in_win) begin
            r_ram_rdaddr <= {w_bank, w_row_base + w_col};
        end
    end

    // Delay lines: in_win and the last-address strobe travel RAM_LAT stages
    // so they line up with ram_rddata; the output register adds the final
    // cycle. A frame start flushes a pending frame_done.
    always_ff @(posedge TFT_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_win_pipe  <= '0;
            r_done_pipe <= '0;
        end else begin
            r_win_pipe[0]  <= w_in_win;
            r_done_pipe[0] <= w_last_pix;
            for (int i = 1; i < int'(RAM_LAT); i++) begin
                r_win_pipe[i]  <= r_win_pipe[i-1];
                r_done_pipe[i] <= w_frame_start ? 1'b0 : r_done_pipe[i-1];
            end
        end
    end

    // Registered pixel / frame_done outputs.
    always_ff @(posedge TFT_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_data  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_disp_data  <= r_win_pipe[RAM_LAT-1] ? tft.ram_rddata : BG_COLOR;
            r_frame_done <= r_done_pipe[RAM_LAT-1] && !w_frame_start;
        end
    end

    assign tft.ram_rdaddr = r_ram_rdaddr;
    assign tft.disp_data  = r_disp_data;
    assign tft.frame_done = r_frame_done;
    assign tft.cur_bank   = r_cur_bank;

endmodule

// File: doc/tft_window_reader.md
Name: tft_window_reader

Overview:
- Parametrised read-side controller between the dual-port frame RAM and the TFT timing generator (TFT_CLK domain).
- Places an IMG_W x IMG_H image at a configurable window origin, with optional 2x pixel replication and double-buffered bank selection.
- Fixed, RAM-latency-compensated pipeline aligns RAM read data with window enable.
- Pixels outside the window output a background colour.

Parameters:
- DATA_W, 16, pixel width (RGB565).
- CNT_W, 11, width of h_cnt/v_cnt.
- PIX_AW, 16, per-bank pixel address width.
- IMG_W, 256, stored image width in pixels.
- IMG_H, 256, stored image height in pixels.
- WIN_X, 272, first displayed column (h_cnt value).
- WIN_Y, 112, first displayed row (v_cnt value).
- RAM_LAT, 1, RAM read latency in TFT_CLK cycles (1..3).
- BG_COLOR, 16'h0000, colour outside the window.

Ports:
- TFT_CLK  in  1  pixel clock.
- rst_n  in  1  reset, asynchronous, active-low.
- data_req  in  1  timing generator requests a pixel for (h_cnt, v_cnt).
- h_cnt  in  CNT_W  current column.
- v_cnt  in  CNT_W  current row.
- scale_2x  in  1  0 = 1x, 1 = 2x replication; sampled at frame start.
- bank_sel  in  1  bank to display; sampled at frame start.
- ram_rdaddr  out  PIX_AW+1  RAM read address {bank, pixel}.
- ram_rddata  in  DATA_W  RAM read data, valid RAM_LAT cycles after the address.
- disp_data  out  DATA_W  pixel to the timing generator.
- frame_done  out  1  one-cycle pulse after the last window address of a frame.
- cur_bank  out  1  bank latched for the current frame.

Behaviour:
- Reset (asynchronous, rst_n low):
  - ram_rdaddr = 0, disp_data = 0, frame_done = 0, cur_bank = 0.
  - Internal scale = 0, row_base = 0, col/row sub-counters = 0.
  - Pipeline valid bits cleared.
  - A reset mid-frame aborts the frame; normal operation resumes at the next frame start.
- Frame start is the cycle where h_cnt == 0 && v_cnt == 0. On this cycle:
  - latch scale_2x into scale and bank_sel into cur_bank;
  - clear row_base, column counter, line sub-counter and the frame_done-armed flag.
  - Changes on scale_2x or bank_sel at any other time have no effect until the next frame start.
- Effective window size:
  - W_EFF = IMG_W << scale, H_EFF = IMG_H << scale.
  - in_win = data_req && WIN_X <= h_cnt < WIN_X + W_EFF && WIN_Y <= v_cnt < WIN_Y + H_EFF.
  - Comparisons use CNT_W+1 bits so the window end cannot overflow.
- Addressing (counter based, no multiplier):
  - Each in_win cycle, ram_rdaddr <= {cur_bank, row_base + col}.
  - col advances by 1 every (1 << scale) in_win cycles.
  - col clears on the first cycle with h_cnt == WIN_X + W_EFF (line end).
  - At line end on a window row:
    - 1x: row_base += IMG_W.
    - 2x: row_base += IMG_W only on every second line; odd lines re-read the same row.
  - Pixel address arithmetic is modulo 2^PIX_AW (wraps inside the bank, never carries into the bank bit).
  - Outside in_win, ram_rdaddr holds its last value.
- Pipeline:
  - in_win is delayed through a shift register of RAM_LAT+1 stages.
  - disp_data is registered: ram_rddata when the delayed in_win is 1, else BG_COLOR.
  - Total latency from a (data_req, h_cnt, v_cnt) sample to the matching disp_data is RAM_LAT+1 cycles. The timing generator compensates.
- frame_done:
  - Asserts for exactly one cycle, RAM_LAT+1 cycles after the cycle that issued the last window address (h = WIN_X+W_EFF-1, v = WIN_Y+H_EFF-1).
  - Fires at most once per frame (armed flag).
  - Not asserted if reset or frame start intervenes first.
- data_req low inside the geometric window: no address is issued, counters do not advance, and disp_data = BG_COLOR for that slot.
- Simultaneous frame start and in_win (WIN_X = WIN_Y = 0): the frame-start clears take effect first, and the first address issued is {bank_sel, 0}.

Test Plan:
1. Reset, then one frame, defaults, scale_2x=0, bank_sel=0, RAM preloaded with data = address -> ram_rdaddr runs 0..65535 over 256 rows; disp_data at (272,112)+2 cycles = 0x0000, at (527,367)+2 = 0xFFFF; BG_COLOR elsewhere; single frame_done pulse.
2. scale_2x=1 latched at frame start -> window spans h 272..783, v 112..623; each address is held for 2 cycles; rows 112 and 113 both read 0..255; row_base reaches 65280 on row 622.
3. Toggle bank_sel and scale_2x mid-frame -> no change in the current frame; next frame uses ram_rdaddr[16]=1 and the new scale; cur_bank updates only at (0,0).
4. Deassert data_req for 5 cycles at h=300, v=200 -> those 5 disp_data slots = BG_COLOR; the address sequence resumes from the same col with no skipped pixel.
5. Pulse rst_n low at v=250 mid-window -> all outputs 0 immediately; no frame_done this frame; the next frame restarts at address 0 with correct pixels.
6. RAM_LAT=2 build -> disp_data matches the RAM model 3 cycles after each in_win sample; first/last window pixels are aligned with no BG_COLOR insertion.
